rr_bus_arbiter: RTL and testbench
=================================

// Module: rr_bus_arbiter
//
// PURPOSE
//  N-requester bus arbiter with registered one-hot grant and round-robin fairness.
//  Owner keeps the bus while its request stays high (burst ownership).
//  Optional hold limit forces hand-over when other requesters are waiting.
//  Sits between N bus masters and the shared bus mux; gnt drives the mux selects.
//
// PARAMETERS
//  N         4   number of requesters, 2..16
//  MAX_HOLD  8   max consecutive grant cycles while others wait; 0 = unlimited
//  ID_W      derived, max(1,clog2(N)); width of gnt_id
//  CNT_W     derived, max(1,clog2(MAX_HOLD+1)); width of hold counter
//
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, asynchronous, active-high
//  req         in   N      request per master, level; bit i = master i
//  gnt         out  N      registered one-hot grant, or all-zero when idle
//  gnt_valid   out  1      registered; equals |gnt
//  gnt_id      out  ID_W   registered index of granted master; 0 when idle
//  preempt     out  1      registered 1-cycle pulse: the last grant change was forced by MAX_HOLD
//
// BEHAVIOUR
//  - Reset: gnt=0, gnt_valid=0, gnt_id=0, preempt=0, hold_cnt=0, last_owner=N-1.
//    With last_owner=N-1, master 0 has highest priority after reset.
//  - All state updates on posedge clk. gnt/gnt_id/preempt change only at edges.
//  - Latency: req rising while idle -> gnt at the next edge (1 cycle).
//  - Per-edge decision. cur = current owner. others = req & ~gnt.
//    a) idle (gnt=0): grant first set req bit searching last_owner+1, +2, ... (mod N).
//       No req -> stay idle.
//    b) owner active, req[cur]=1, and (others==0 or MAX_HOLD==0 or hold_cnt<MAX_HOLD-1):
//       keep gnt; hold_cnt += 1, saturating at MAX_HOLD.
//    c) owner active, req[cur]=1, others!=0, hold_cnt==MAX_HOLD-1:
//       grant next others bit searching from cur+1 (mod N); preempt=1 for one cycle.
//    d) owner active, req[cur]=0: hand over directly, with no idle gap, to the next req bit
//       searching from cur+1. No req -> idle. preempt=0.
//  - On any grant change: hold_cnt=0 and last_owner=new owner.
//    When going idle, last_owner keeps the previous owner.
//  - Sole requester is never preempted. hold_cnt saturates and does not wrap.
//  - Simultaneous owner drop and new requests: case (d). Rotation starts from cur+1.
//    The owner is not re-granted in the same edge even if req[cur] re-asserts later.
//  - Pointer wrap: the search from N-1 continues at 0.
//  - Reset mid-burst: grant drops asynchronously. After release, case (a) with master 0 first.
//  - Invariants: gnt one-hot or zero; gnt_valid==|gnt; gnt_id==index(gnt).
//    gnt[i]=1 is entered only at an edge where req[i]=1 was sampled.
//
// STRUCTURE
//  - Shared package arb_pkg: function clog2_min1(int), localparam MAX_N=16.
//    The rr_bus_arbiter and future arbiters use these.
//  - Sub-module rr_pick (combinational): inputs vec[N] and start[ID_W];
//    outputs found and idx[ID_W] = first set bit at or after start, mod N.
//    Implemented as double-width vector rotate + priority encode.
//  - Top: state regs (gnt, gnt_id, hold_cnt, last_owner, preempt) + next-state case a-d.
//    Uses one rr_pick instance; its vec input is req or others, selected by case.
//
// TESTING  (N=4, MAX_HOLD=4 unless noted)
//  1 Reset then req=0001 for 3 cycles, then 0000
//    -> gnt=0001 one edge after req, gnt_id=0; gnt=0 one edge after drop.
//  2 req=1111 held constant
//    -> gnt sequence 0001(4 cyc),0010(4),0100(4),1000(4),0001...; preempt pulses at each change.
//  3 req=0101; owner 0 drops req after 2 cycles
//    -> gnt 0001 -> 0100 on the next edge, no idle cycle; preempt=0.
//  4 Sole requester req=0010 for 20 cycles
//    -> gnt=0010 throughout; hold_cnt saturates at 4; preempt never asserts.
//  5 MAX_HOLD=0, req=0011 for 30 cycles
//    -> master 0 keeps the grant all 30 cycles; then req=0010 -> gnt=0010 next edge.
//  6 rst pulsed mid-burst while gnt=0100 with req=1111
//    -> gnt=0 immediately (async); first grant after release is 0001.
//  All tests: assertion checks on the one-hot/zero, gnt_valid and gnt_id invariants every cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the bus arbiter family: width helper, requester
// limit and the per-edge decision type used by the round-robin arbiter.
package arb_pkg;

    // Largest requester count any arbiter in this family is built for.
    localparam int MAX_N = 16;

    // What the arbiter does with the bus at the coming clock edge.
    typedef enum logic [1:0] {
        DEC_IDLE     = 2'd0,   // nobody owns the bus, look for a new owner
        DEC_KEEP     = 2'd1,   // owner keeps the bus for another cycle
        DEC_PREEMPT  = 2'd2,   // owner hit the hold limit, force hand-over
        DEC_HANDOVER = 2'd3    // owner released its request
    } arbDecision_e;

    // Ceiling log2 that never returns less than one, so a value always
    // gets at least a one-bit field.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set-bit finder: returns the index of the first set bit of
// vec_i at or after start_i, wrapping from N-1 back to 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = clog2_min1(N)
) (
    input  logic [N-1:0]    vec_i,
    input  logic [ID_W-1:0] start_i,
    output logic            found_o,
    output logic [ID_W-1:0] idx_o
);

    localparam logic [ID_W:0] N_VAL = (ID_W + 1)'(N);

    logic [N-1:0]  rotated;
    logic [ID_W:0] offset;
    logic [ID_W:0] sum;

    // Rotate the doubled vector so start_i lands at bit 0, take the lowest
    // set bit as the distance from start, then map back to an absolute index.
    always_comb begin
        rotated = N'({vec_i, vec_i} >> start_i);
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = (ID_W + 1)'(i);
            end
        end
        sum = {1'b0, start_i} + offset;
        if (sum >= N_VAL) begin
            sum = sum - N_VAL;
        end
    end

    assign found_o = |rotated;
    assign idx_o   = sum[ID_W-1:0];

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter for N masters. The grant is registered and one-hot
// (or zero when idle). An owner keeps the bus while its request stays high;
// with MAX_HOLD non-zero it is forced off after MAX_HOLD cycles if anyone
// else is waiting. A sole requester is never forced off.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = clog2_min1(N),
    localparam int CNT_W   = clog2_min1(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic            gnt_valid_o,
    output logic [ID_W-1:0] gnt_id_o,
    output logic            preempt_o
);

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    if (N < 2 || N > MAX_N) begin : gBadN
        $error("rr_bus_arbiter: N must be in 2..%0d", MAX_N);
    end

    logic [N-1:0]     gnt_q,       gnt_d;
    logic [ID_W-1:0]  gntId_q,     gntId_d;
    logic             gntValid_q,  gntValid_d;
    logic [CNT_W-1:0] holdCnt_q,   holdCnt_d;
    logic [ID_W-1:0]  lastOwner_q, lastOwner_d;
    logic             preempt_q,   preempt_d;

    logic [N-1:0]     others;
    logic [ID_W-1:0]  curPlusOne;
    logic [ID_W-1:0]  lastPlusOne;
    arbDecision_e     decision;
    logic [N-1:0]     pickVec;
    logic [ID_W-1:0]  pickStart;
    logic             pickFound;
    logic [ID_W-1:0]  pickIdx;

    function automatic logic [ID_W-1:0] wrapInc(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_W'(1);
    endfunction

    assign others      = req_i & ~gnt_q;
    assign curPlusOne  = wrapInc(gntId_q);
    assign lastPlusOne = wrapInc(lastOwner_q);

    // Classify the coming edge and choose what the shared picker searches:
    // an idle bus resumes after the last owner, every other search starts
    // just past the current owner, and a forced hand-over skips the owner.
    always_comb begin
        decision  = DEC_KEEP;
        pickVec   = req_i;
        pickStart = curPlusOne;
        if (!gntValid_q) begin
            decision  = DEC_IDLE;
            pickStart = lastPlusOne;
        end else if (!req_i[gntId_q]) begin
            decision = DEC_HANDOVER;
        end else if ((|others) && (MAX_HOLD != 0) && (holdCnt_q >= HOLD_LAST)) begin
            decision = DEC_PREEMPT;
            pickVec  = others;
        end
    end

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) uPick (
        .vec_i   (pickVec),
        .start_i (pickStart),
        .found_o (pickFound),
        .idx_o   (pickIdx)
    );

    // Next-state values: keep and count while the owner holds, otherwise
    // move the grant to the picked master (restarting the hold count) or
    // drop to idle while remembering who owned the bus last.
    always_comb begin
        gnt_d       = gnt_q;
        gntId_d     = gntId_q;
        gntValid_d  = gntValid_q;
        holdCnt_d   = holdCnt_q;
        lastOwner_d = lastOwner_q;
        preempt_d   = 1'b0;
        if (decision == DEC_KEEP) begin
            if (holdCnt_q != HOLD_MAX) begin
                holdCnt_d = holdCnt_q + CNT_W'(1);
            end
        end else if (pickFound) begin
            gnt_d       = N'(1) << pickIdx;
            gntId_d     = pickIdx;
            gntValid_d  = 1'b1;
            holdCnt_d   = '0;
            lastOwner_d = pickIdx;
            preempt_d   = (decision == DEC_PREEMPT);
        end else begin
            gnt_d      = '0;
            gntId_d    = '0;
            gntValid_d = 1'b0;
            holdCnt_d  = '0;
        end
    end

    // Arbiter state; reset drops the grant at once and points the rotation
    // at N-1 so master 0 is first in line afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            gntId_q     <= '0;
            gntValid_q  <= 1'b0;
            holdCnt_q   <= '0;
            lastOwner_q <= LAST_ID;
            preempt_q   <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            gntId_q     <= gntId_d;
            gntValid_q  <= gntValid_d;
            holdCnt_q   <= holdCnt_d;
            lastOwner_q <= lastOwner_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gntValid_q;
    assign gnt_id_o    = gntId_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: one instance with MAX_HOLD=4 and
// one with unlimited hold, both driven by the same requests and compared
// every cycle against a behavioural model of the arbitration rules.
module tb_rr_bus_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] gntA;
    logic       gntValidA;
    logic [1:0] gntIdA;
    logic       preemptA;
    logic [3:0] gntB;
    logic       gntValidB;
    logic [1:0] gntIdB;
    logic       preemptB;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: owner index (-1 = idle), cycles held,
    // last owner, preempt pulse and the hold limit of that instance.
    int ownerM[2];
    int holdM[2];
    int lastM[2];
    bit preM[2];
    int maxHoldM[2] = '{4, 0};

    typedef struct {
        bit         rstBefore;
        logic [3:0] req;
        logic [3:0] expGnt;
        logic       expPre;
    } vector_t;

    vector_t vectors[$];

    always #5 clk = ~clk;

    rr_bus_arbiter #(
        .N        (4),
        .MAX_HOLD (4)
    ) dutA (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .gnt_o       (gntA),
        .gnt_valid_o (gntValidA),
        .gnt_id_o    (gntIdA),
        .preempt_o   (preemptA)
    );

    rr_bus_arbiter #(
        .N        (4),
        .MAX_HOLD (0)
    ) dutB (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .gnt_o       (gntB),
        .gnt_valid_o (gntValidB),
        .gnt_id_o    (gntIdB),
        .preempt_o   (preemptB)
    );

    function automatic int firstFrom(input logic [3:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int indexOf(input logic [3:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            ownerM[m] = -1;
            holdM[m]  = 0;
            lastM[m]  = N - 1;
            preM[m]   = 1'b0;
        end
    endtask

    task automatic modelStep(input int m, input logic [3:0] r);
        int         o;
        logic [3:0] waiting;
        preM[m] = 1'b0;
        if (ownerM[m] < 0) begin
            o = firstFrom(r, lastM[m] + 1);
            if (o >= 0) begin
                ownerM[m] = o;
                lastM[m]  = o;
                holdM[m]  = 0;
            end
        end else if (!r[ownerM[m]]) begin
            o = firstFrom(r, ownerM[m] + 1);
            ownerM[m] = o;
            holdM[m]  = 0;
            if (o >= 0) lastM[m] = o;
        end else begin
            waiting = r & ~(4'b0001 << ownerM[m]);
            if (waiting != 4'b0000 && maxHoldM[m] != 0 && holdM[m] >= maxHoldM[m] - 1) begin
                o = firstFrom(waiting, ownerM[m] + 1);
                ownerM[m] = o;
                lastM[m]  = o;
                holdM[m]  = 0;
                preM[m]   = 1'b1;
            end else if (holdM[m] < maxHoldM[m]) begin
                holdM[m]++;
            end
        end
    endtask

    task automatic checkInstance(input string tag, input int m, input logic [3:0] g,
                                 input logic v, input logic [1:0] id, input logic p);
        checkOutput({tag, " gnt"},     g,  (ownerM[m] < 0) ? 0 : (1 << ownerM[m]));
        checkOutput({tag, " valid"},   v,  (ownerM[m] < 0) ? 0 : 1);
        checkOutput({tag, " id"},      id, (ownerM[m] < 0) ? 0 : ownerM[m]);
        checkOutput({tag, " preempt"}, p,  preM[m]);
        checkOutput({tag, " onehot0"}, ($countones(g) <= 1) ? 1 : 0, 1);
        checkOutput({tag, " valid==|gnt"}, v, |g);
        checkOutput({tag, " id==index"}, id, indexOf(g));
    endtask

    // Drive one request pattern for one clock edge, advance the model on
    // the same edge and compare both instances half a cycle later.
    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(posedge clk);
        modelStep(0, r);
        modelStep(1, r);
        @(negedge clk);
        checkInstance("A", 0, gntA, gntValidA, gntIdA, preemptA);
        checkInstance("B", 1, gntB, gntValidB, gntIdB, preemptB);
    endtask

    task automatic doReset();
        req = 4'b0000;
        rst = 1'b1;
        modelReset();
        #2;
        checkOutput("rst gntA",   gntA,      0);
        checkOutput("rst validA", gntValidA, 0);
        checkOutput("rst idA",    gntIdA,    0);
        checkOutput("rst preA",   preemptA,  0);
        checkOutput("rst gntB",   gntB,      0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void addVec(input bit rb, input logic [3:0] r,
                                   input logic [3:0] g, input logic p);
        vector_t v;
        v.rstBefore = rb;
        v.req       = r;
        v.expGnt    = g;
        v.expPre    = p;
        vectors.push_back(v);
    endfunction

    initial begin
        logic [3:0] r;
        int         guard;

        rst = 1'b1;
        req = 4'b0000;
        modelReset();

        // Single requester then release.
        addVec(1, 4'b0001, 4'b0001, 0);
        addVec(0, 4'b0001, 4'b0001, 0);
        addVec(0, 4'b0001, 4'b0001, 0);
        addVec(0, 4'b0000, 4'b0000, 0);
        // Everyone requesting: four cycles each, preempt at each change.
        for (int k = 0; k < 17; k++) begin
            addVec(k == 0, 4'b1111, 4'(1 << ((k / 4) % 4)), (k >= 4) && (k % 4 == 0));
        end
        // Owner drops: immediate hand-over, no idle gap.
        addVec(1, 4'b0101, 4'b0001, 0);
        addVec(0, 4'b0101, 4'b0001, 0);
        addVec(0, 4'b0100, 4'b0100, 0);
        addVec(0, 4'b0000, 4'b0000, 0);
        // Wrap from master 3 to 0, and drop with new requests searching past owner.
        addVec(1, 4'b1000, 4'b1000, 0);
        addVec(0, 4'b0001, 4'b0001, 0);
        addVec(0, 4'b0110, 4'b0010, 0);
        addVec(0, 4'b0111, 4'b0010, 0);
        addVec(0, 4'b0101, 4'b0100, 0);
        // Sole requester keeps bus; once saturated a newcomer forces hand-over.
        for (int k = 0; k < 20; k++) begin
            addVec(k == 0, 4'b0010, 4'b0010, 0);
        end
        addVec(0, 4'b0011, 4'b0001, 1);

        foreach (vectors[i]) begin
            if (vectors[i].rstBefore) doReset();
            applyStimulus(vectors[i].req);
            checkOutput($sformatf("vec%0d gnt", i), gntA, vectors[i].expGnt);
            checkOutput($sformatf("vec%0d preempt", i), preemptA, vectors[i].expPre);
        end

        // Unlimited hold: master 0 keeps the bus for the whole burst.
        doReset();
        for (int k = 0; k < 30; k++) begin
            applyStimulus(4'b0011);
            checkOutput($sformatf("nohold cyc%0d gnt", k), gntB, 4'b0001);
        end
        applyStimulus(4'b0010);
        checkOutput("nohold handover gnt", gntB, 4'b0010);

        // Reset in the middle of master 2's burst drops the grant at once.
        doReset();
        guard = 0;
        while (gntA != 4'b0100 && guard < 40) begin
            applyStimulus(4'b1111);
            guard++;
        end
        checkOutput("reach master2 gnt", gntA, 4'b0100);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async rst gnt",   gntA,      0);
        checkOutput("async rst valid", gntValidA, 0);
        checkOutput("async rst id",    gntIdA,    0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b1111);
        checkOutput("post rst gnt", gntA, 4'b0001);

        // Random bursty traffic against the model.
        doReset();
        r = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            applyStimulus(r);
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
